// File: rtl/fx2_slave_fifo_model_pkg.sv
// Shared definitions for the FX2 slave-FIFO endpoint emulator.
//   ep_addr_e : usb_addr encoding of the four endpoints
//   Err*      : bit positions inside the sticky err vector
//   is_out_ep : true for the host->FPGA endpoints (EP2/EP4)
package fx2_slave_fifo_model_pkg;

  typedef enum logic [1:0] {
    Ep2 = 2'd0,
    Ep4 = 2'd1,
    Ep6 = 2'd2,
    Ep8 = 2'd3
  } ep_addr_e;

  localparam int unsigned NumEp = 4;

  localparam int unsigned ErrRdBad = 0;  // slrd on empty FIFO or on an IN endpoint
  localparam int unsigned ErrWrBad = 1;  // slwr on full FIFO or on an OUT endpoint
  localparam int unsigned ErrRdWr  = 2;  // slrd and slwr in the same cycle
  localparam int unsigned ErrHost  = 3;  // host overrun or underrun

  function automatic logic is_out_ep(logic [1:0] addr);
    return ~addr[1];
  endfunction

endpackage

// File: rtl/fx2_slave_fifo_model_if.sv
// Bus bundle between the FPGA master / host model and the FX2 endpoint emulator.
// modport slave  : the emulator (fx2_slave_fifo_model)
// modport master : whoever drives the FX2 strobes and the host-side port
// usb_pktend exists only when FX2_PKTEND_EN is defined.
interface fx2_slave_fifo_model_if;
  logic       usb_slwr;
  logic       usb_slrd;
  logic       usb_sloe;
  logic [1:0] usb_addr;
  logic [7:0] usb_data_in;
  logic [7:0] usb_data_out;
  logic       usb_ep2_empty;
  logic       usb_ep4_empty;
  logic       usb_ep6_full;
  logic       usb_ep8_full;
`ifdef FX2_PKTEND_EN
  logic       usb_pktend;
`endif
  logic       host_wr_en;
  logic       host_wr_ep;
  logic [7:0] host_wr_data;
  logic [1:0] host_wr_full;
  logic       host_rd_en;
  logic       host_rd_ep;
  logic [7:0] host_rd_data;
  logic [1:0] host_rd_avail;
  logic [3:0] err;
  logic       err_clear;

  modport slave (
`ifdef FX2_PKTEND_EN
    input  usb_pktend,
`endif
    input  usb_slwr, usb_slrd, usb_sloe, usb_addr, usb_data_in,
    output usb_data_out, usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
    input  host_wr_en, host_wr_ep, host_wr_data, host_rd_en, host_rd_ep, err_clear,
    output host_wr_full, host_rd_data, host_rd_avail, err
  );

  modport master (
`ifdef FX2_PKTEND_EN
    output usb_pktend,
`endif
    output usb_slwr, usb_slrd, usb_sloe, usb_addr, usb_data_in,
    input  usb_data_out, usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
    output host_wr_en, host_wr_ep, host_wr_data, host_rd_en, host_rd_ep, err_clear,
    input  host_wr_full, host_rd_data, host_rd_avail, err
  );
endinterface

// File: rtl/fx2_slave_fifo_model_ep_fifo.sv
// One endpoint byte FIFO with first-word fall-through head.
//   clk, reset : clock, asynchronous active-low reset (pointers/count only)
//   i_push     : write i_data at the tail (ignored when full)
//   i_pop      : drop the head (ignored when empty)
//   o_head     : current head byte (undefined when empty)
//   o_empty    : occupancy is zero
//   o_full     : occupancy is 2**DEPTH_LOG2
module fx2_slave_fifo_model_ep_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  // Count never exceeds Depth, so its MSB is set only when exactly full.
  assign o_full  = r_count[DEPTH_LOG2];

endmodule

// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO endpoint emulator (USB-chip side) for cosim / FPGA loopback.
//   clk   : single clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : fx2_slave_fifo_model_if.slave -- FPGA strobes/flags, host port, err
// EP2/EP4 carry host->FPGA bytes, EP6/EP8 carry FPGA->host bytes.
// Optional FX2_PKTEND_EN: IN bytes become host-visible only once committed, either
// after PKT_SIZE bytes or by a usb_pktend pulse addressed to that endpoint.
module fx2_slave_fifo_model
  import fx2_slave_fifo_model_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PKT_SIZE   = 512
) (
  input logic                   clk,
  input logic                   reset,
  fx2_slave_fifo_model_if.slave bus
);

  if (PKT_SIZE < 1 || PKT_SIZE > 2 ** DEPTH_LOG2) begin : g_bad_pkt_size
    $error("PKT_SIZE out of range");
  end

  logic [NumEp-1:0] w_push;
  logic [NumEp-1:0] w_pop;
  logic [NumEp-1:0] w_empty;
  logic [NumEp-1:0] w_full;
  logic [7:0]       w_head [NumEp];
  logic [1:0]       w_avail;  // host-visible data present, {EP8, EP6}
  logic             w_rd_only;
  logic             w_wr_only;
  logic             w_fx_pop_ok;
  logic             w_fx_push_ok;
  logic             w_host_push_ok;
  logic             w_host_pop_ok;
  logic [3:0]       w_new_err;
  logic [3:0]       r_err;

  for (genvar g = 0; g < NumEp; g++) begin : g_ep
    fx2_slave_fifo_model_ep_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_push[g]),
      .i_pop  (w_pop[g]),
      .i_data ((g < 2) ? bus.host_wr_data : bus.usb_data_in),
      .o_head (w_head[g]),
      .o_empty(w_empty[g]),
      .o_full (w_full[g])
    );
  end

  // Simultaneous slrd/slwr cancels both strobes.
  assign w_rd_only = bus.usb_slrd & ~bus.usb_slwr;
  assign w_wr_only = bus.usb_slwr & ~bus.usb_slrd;

  assign w_fx_pop_ok    = w_rd_only & is_out_ep(bus.usb_addr) & ~w_empty[bus.usb_addr];
  assign w_fx_push_ok   = w_wr_only & ~is_out_ep(bus.usb_addr) & ~w_full[bus.usb_addr];
  assign w_host_push_ok = bus.host_wr_en & ~w_full[{1'b0, bus.host_wr_ep}];
  assign w_host_pop_ok  = bus.host_rd_en & w_avail[bus.host_rd_ep];

  // Host and FX2 sides always address opposite ends of a FIFO, so both may act at once.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    if (w_fx_pop_ok)    w_pop[bus.usb_addr]              = 1'b1;
    if (w_fx_push_ok)   w_push[bus.usb_addr]             = 1'b1;
    if (w_host_push_ok) w_push[{1'b0, bus.host_wr_ep}]   = 1'b1;
    if (w_host_pop_ok)  w_pop[{1'b1, bus.host_rd_ep}]    = 1'b1;
  end

  always_comb begin
    w_new_err           = '0;
    w_new_err[ErrRdBad] = w_rd_only & (~is_out_ep(bus.usb_addr) | w_empty[bus.usb_addr]);
    w_new_err[ErrWrBad] = w_wr_only & (is_out_ep(bus.usb_addr) | w_full[bus.usb_addr]);
    w_new_err[ErrRdWr]  = bus.usb_slrd & bus.usb_slwr;
    w_new_err[ErrHost]  = (bus.host_wr_en & ~w_host_push_ok) | (bus.host_rd_en & ~w_host_pop_ok);
  end

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= '0;
    else        r_err <= (bus.err_clear ? 4'b0000 : r_err) | w_new_err;
  end

`ifdef FX2_PKTEND_EN
  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  // Per IN endpoint: committed-unread bytes and bytes written since the last commit.
  logic [CntW-1:0] r_commit [2];
  logic [CntW-1:0] r_pend   [2];
  logic [CntW-1:0] w_commit_nx [2];
  logic [CntW-1:0] w_pend_nx   [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_pend_nx[i]   = r_pend[i] + CntW'(w_push[2+i]);
      w_commit_nx[i] = r_commit[i] - CntW'(w_pop[2+i]);
      // Commit includes a byte written in the same cycle as usb_pktend.
      if ((w_pend_nx[i] == CntW'(PKT_SIZE)) ||
          (bus.usb_pktend && bus.usb_addr == {1'b1, 1'(i)})) begin
        w_commit_nx[i] = w_commit_nx[i] + w_pend_nx[i];
        w_pend_nx[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_commit[i] <= '0;
        r_pend[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_commit[i] <= w_commit_nx[i];
        r_pend[i]   <= w_pend_nx[i];
      end
    end
  end

  assign w_avail[0] = (r_commit[0] != '0);
  assign w_avail[1] = (r_commit[1] != '0);
`else
  assign w_avail = ~w_empty[3:2];
`endif

  assign bus.usb_data_out  = (bus.usb_sloe && is_out_ep(bus.usb_addr) && !w_empty[bus.usb_addr])
                             ? w_head[bus.usb_addr] : 8'h00;
  assign bus.usb_ep2_empty = w_empty[Ep2];
  assign bus.usb_ep4_empty = w_empty[Ep4];
  assign bus.usb_ep6_full  = w_full[Ep6];
  assign bus.usb_ep8_full  = w_full[Ep8];
  assign bus.host_wr_full  = w_full[1:0];
  assign bus.host_rd_avail = w_avail;
  assign bus.host_rd_data  = w_avail[bus.host_rd_ep] ? w_head[{1'b1, bus.host_rd_ep}] : 8'h00;
  assign bus.err           = r_err;

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Bench for fx2_slave_fifo_model: table-driven error/decode vectors, directed multi-cycle
// sequences, and randomized traffic checked against a queue-based endpoint model.
module tb_fx2_slave_fifo_model;

  localparam int DepthLog2 = 9;
  localparam int Depth     = 512;
  localparam int PktSize   = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fx2_slave_fifo_model_if bus ();

  fx2_slave_fifo_model #(
    .DEPTH_LOG2(DepthLog2),
    .PKT_SIZE  (PktSize)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       slrd, slwr, sloe;
    logic [1:0] addr;
    logic [7:0] din;
    logic       hwr, hwep;
    logic [7:0] hwd;
    logic       hrd, hrep, clr, pktend;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] exp_err;
    logic       exp_ep2_empty;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per endpoint, sticky error bits, commit bookkeeping.
  logic [7:0] q [4][$];
  logic [3:0] m_err;
  int         m_commit [2];
  int         m_pend   [2];
  stim_t      cur;

  function automatic stim_t idle();
    stim_t s;
    s.slrd = 0; s.slwr = 0; s.sloe = 0; s.addr = 0; s.din = 0;
    s.hwr = 0; s.hwep = 0; s.hwd = 0; s.hrd = 0; s.hrep = 0; s.clr = 0; s.pktend = 0;
    return s;
  endfunction

  function automatic bit m_avail(int e);
`ifdef FX2_PKTEND_EN
    return m_commit[e] > 0;
`else
    return q[2+e].size() > 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    cur = s;
    bus.usb_slrd     = s.slrd;
    bus.usb_slwr     = s.slwr;
    bus.usb_sloe     = s.sloe;
    bus.usb_addr     = s.addr;
    bus.usb_data_in  = s.din;
    bus.host_wr_en   = s.hwr;
    bus.host_wr_ep   = s.hwep;
    bus.host_wr_data = s.hwd;
    bus.host_rd_en   = s.hrd;
    bus.host_rd_ep   = s.hrep;
    bus.err_clear    = s.clr;
`ifdef FX2_PKTEND_EN
    bus.usb_pktend   = s.pktend;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) q[i].delete();
    m_err = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      m_commit[i] = 0;
      m_pend[i]   = 0;
    end
  endtask

  // Applies one clock edge's worth of endpoint rules to the model.
  task automatic model_update(input stim_t s);
    int a;
    logic [3:0] ne;
    bit fx_pop, fx_push, h_push, h_pop;
    a = int'(s.addr);
    ne = 4'b0000;
    fx_pop = 0; fx_push = 0; h_push = 0; h_pop = 0;
    if (s.slrd && s.slwr) ne[2] = 1'b1;
    else if (s.slrd) begin
      if (a < 2 && q[a].size() > 0) fx_pop = 1; else ne[0] = 1'b1;
    end else if (s.slwr) begin
      if (a >= 2 && q[a].size() < Depth) fx_push = 1; else ne[1] = 1'b1;
    end
    if (s.hwr) begin
      if (q[s.hwep].size() < Depth) h_push = 1; else ne[3] = 1'b1;
    end
    if (s.hrd) begin
      if (m_avail(s.hrep)) h_pop = 1; else ne[3] = 1'b1;
    end
    if (fx_pop) void'(q[a].pop_front());
    if (h_pop)  void'(q[2+s.hrep].pop_front());
    if (fx_push) q[a].push_back(s.din);
    if (h_push)  q[s.hwep].push_back(s.hwd);
    for (int e = 0; e < 2; e++) begin
      if (h_pop && s.hrep == e) m_commit[e]--;
      if (fx_push && a == 2 + e) m_pend[e]++;
`ifdef FX2_PKTEND_EN
      if (m_pend[e] == PktSize || (s.pktend && a == 2 + e)) begin
        m_commit[e] += m_pend[e];
        m_pend[e] = 0;
      end
`endif
    end
    m_err = (s.clr ? 4'b0000 : m_err) | ne;
  endtask

  task automatic compare_all();
    logic [7:0] e_dout, e_hrd;
    int a;
    a = int'(cur.addr);
    e_dout = (cur.sloe && a < 2 && q[a].size() > 0) ? q[a][0] : 8'h00;
    e_hrd  = m_avail(cur.hrep) ? q[2+cur.hrep][0] : 8'h00;
    chk("usb_data_out",  bus.usb_data_out, e_dout);
    chk("usb_ep2_empty", bus.usb_ep2_empty, q[0].size() == 0);
    chk("usb_ep4_empty", bus.usb_ep4_empty, q[1].size() == 0);
    chk("usb_ep6_full",  bus.usb_ep6_full, q[2].size() == Depth);
    chk("usb_ep8_full",  bus.usb_ep8_full, q[3].size() == Depth);
    chk("host_wr_full",  bus.host_wr_full, {q[1].size() == Depth, q[0].size() == Depth});
    chk("host_rd_avail", bus.host_rd_avail, {m_avail(1), m_avail(0)});
    chk("host_rd_data",  bus.host_rd_data, e_hrd);
    chk("err",           bus.err, m_err);
  endtask

  // Call at a negedge: inputs apply to the next posedge, outputs compared at the negedge after.
  task automatic step(input stim_t s);
    drive(s);
    @(posedge clk);
    model_update(s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(idle());
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    compare_all();
  endtask

  vec_t  vecs [9];
  stim_t s;

  initial begin
    model_clear();
    drive(idle());

    // Vectors run from reset; expectations derived by hand from the endpoint rules.
    for (int i = 0; i < 9; i++) vecs[i].s = idle();
    vecs[0].s.slrd = 1; vecs[0].s.addr = 2'd0;                   // read empty EP2
    vecs[0].exp_err = 4'b0001; vecs[0].exp_ep2_empty = 1;
    vecs[1].s.clr = 1; vecs[1].s.hwr = 1; vecs[1].s.hwd = 8'h33; // clear, host fills EP2
    vecs[1].exp_err = 4'b0000; vecs[1].exp_ep2_empty = 0;
    vecs[2].s.slwr = 1; vecs[2].s.addr = 2'd0;                   // write to OUT EP
    vecs[2].exp_err = 4'b0010; vecs[2].exp_ep2_empty = 0;
    vecs[3].s.slwr = 1; vecs[3].s.slrd = 1; vecs[3].s.addr = 2'd0; // collision, no pop
    vecs[3].exp_err = 4'b0110; vecs[3].exp_ep2_empty = 0;
    vecs[4].s.slrd = 1; vecs[4].s.addr = 2'd2;                   // read from IN EP
    vecs[4].exp_err = 4'b0111; vecs[4].exp_ep2_empty = 0;
    vecs[5].s.clr = 1; vecs[5].s.slrd = 1; vecs[5].s.addr = 2'd1; // error beats clear
    vecs[5].exp_err = 4'b0001; vecs[5].exp_ep2_empty = 0;
    vecs[6].s.clr = 1; vecs[6].s.hrd = 1;                        // host underrun on EP6
    vecs[6].exp_err = 4'b1000; vecs[6].exp_ep2_empty = 0;
    vecs[7].s.clr = 1; vecs[7].s.slrd = 1; vecs[7].s.sloe = 1; vecs[7].s.addr = 2'd0;
    vecs[7].exp_err = 4'b0000; vecs[7].exp_ep2_empty = 1;
    vecs[8].exp_err = 4'b0000; vecs[8].exp_ep2_empty = 1;

    // Reset state
    do_reset();
    chk("rst_ep2_empty", bus.usb_ep2_empty, 1);
    chk("rst_ep4_empty", bus.usb_ep4_empty, 1);
    chk("rst_ep6_full",  bus.usb_ep6_full, 0);
    chk("rst_avail",     bus.host_rd_avail, 0);
    chk("rst_err",       bus.err, 0);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].s);
      chk($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
      chk($sformatf("vec%0d_ep2_empty", i), bus.usb_ep2_empty, vecs[i].exp_ep2_empty);
    end

    // Host fills EP2 with 0x01..0x10, FPGA reads them back in order
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      s = idle(); s.hwr = 1; s.hwd = 8'(i);
      step(s);
    end
    s = idle(); s.sloe = 1;
    step(s);
    chk("seq_first_head", bus.usb_data_out, 8'h01);
    for (int k = 0; k < 16; k++) begin
      s = idle(); s.slrd = 1; s.sloe = 1;
      step(s);
      chk("seq_head", bus.usb_data_out, (k < 15) ? 8'(k + 2) : 8'h00);
      chk("seq_ep2_empty", bus.usb_ep2_empty, k == 15);
    end

    // Fill EP6, overflow, drain through the host port
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      s = idle(); s.slwr = 1; s.addr = 2'd2; s.din = 8'(i) ^ 8'h5A;
      step(s);
      if (i == Depth - 2) chk("ep6_not_full", bus.usb_ep6_full, 0);
    end
    chk("ep6_full", bus.usb_ep6_full, 1);
    s = idle(); s.slwr = 1; s.addr = 2'd2; s.din = 8'hEE;
    step(s);
    chk("ep6_overflow_err", bus.err[1], 1);
    for (int i = 0; i < Depth; i++) begin
      chk("ep6_drain", bus.host_rd_data, 8'(i) ^ 8'h5A);
      s = idle(); s.hrd = 1;
      step(s);
    end
    chk("ep6_drained_avail", bus.host_rd_avail, 2'b00);

    // Simultaneous host push and FPGA pop on EP2: one byte, empty, and full
    do_reset();
    s = idle(); s.hwr = 1; s.hwd = 8'h10;
    step(s);
    s = idle(); s.hwr = 1; s.hwd = 8'hAA; s.slrd = 1; s.sloe = 1;
    step(s);
    chk("both_one_head", bus.usb_data_out, 8'hAA);
    chk("both_one_empty", bus.usb_ep2_empty, 0);
    s = idle(); s.slrd = 1;
    step(s);
    s = idle(); s.hwr = 1; s.hwd = 8'hCC; s.slrd = 1;
    step(s);
    chk("both_zero_empty", bus.usb_ep2_empty, 0);
    chk("both_zero_err", bus.err, 4'b0001);
    for (int i = 1; i < Depth; i++) begin
      s = idle(); s.hwr = 1; s.hwd = 8'(i);
      step(s);
    end
    chk("both_full_flag", bus.host_wr_full, 2'b01);
    s = idle(); s.hwr = 1; s.hwd = 8'hBB; s.slrd = 1; s.sloe = 1;
    step(s);
    chk("both_full_flag_after", bus.host_wr_full, 2'b00);
    chk("both_full_err", bus.err[3], 1);
    chk("both_full_head", bus.usb_data_out, 8'h01);

`ifdef FX2_PKTEND_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.slwr = 1; s.addr = 2'd3; s.din = 8'(8'h70 + i);
      step(s);
    end
    chk("pkt_uncommitted", bus.host_rd_avail[1], 0);
    s = idle(); s.pktend = 1; s.addr = 2'd3;
    step(s);
    chk("pkt_pktend_avail", bus.host_rd_avail[1], 1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.hrd = 1; s.hrep = 1;
      step(s);
    end
    chk("pkt_drained", bus.host_rd_avail[1], 0);
    for (int i = 0; i < PktSize; i++) begin
      s = idle(); s.slwr = 1; s.addr = 2'd3; s.din = 8'(i);
      step(s);
      if (i == PktSize - 2) chk("pkt_before_auto", bus.host_rd_avail[1], 0);
    end
    chk("pkt_auto_commit", bus.host_rd_avail[1], 1);
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      s = idle();
      s.slrd   = ($urandom_range(0, 3) == 0);
      s.slwr   = ($urandom_range(0, 2) == 0);
      s.sloe   = 1'($urandom_range(0, 1));
      s.addr   = 2'($urandom_range(0, 3));
      s.din    = 8'($urandom);
      s.hwr    = ($urandom_range(0, 2) == 0);
      s.hwep   = 1'($urandom_range(0, 1));
      s.hwd    = 8'($urandom);
      s.hrd    = ($urandom_range(0, 3) == 0);
      s.hrep   = 1'($urandom_range(0, 1));
      s.clr    = ($urandom_range(0, 15) == 0);
      s.pktend = ($urandom_range(0, 7) == 0);
      step(s);
    end

    // Asynchronous reset with EP6 half full and an error pending
    do_reset();
    for (int i = 0; i < Depth / 2; i++) begin
      s = idle(); s.slwr = 1; s.addr = 2'd2; s.din = 8'(i);
      step(s);
    end
    s = idle(); s.slrd = 1; s.addr = 2'd1;
    step(s);
    s = idle(); s.pktend = 1; s.addr = 2'd2;
    step(s);
    chk("pre_rst_avail", bus.host_rd_avail[0], 1);
    drive(idle());
    #2 reset = 1'b0;
    #1;
    chk("async_avail", bus.host_rd_avail, 2'b00);
    chk("async_err", bus.err, 4'b0000);
    chk("async_ep6_full", bus.usb_ep6_full, 0);
    chk("async_rd_data", bus.host_rd_data, 8'h00);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    compare_all();
    s = idle(); s.hrd = 1;
    step(s);
    chk("post_rst_underrun", bus.err, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
